instr_exec_unit: RTL and testbench

- Reader and executor at the output side of the 32-entry instruction register.
- On a start command it walks `read_pointer` over a range of entries and samples each `instruction_word`.
- It computes each entry's result: single-cycle ALU for most opcodes, iterative signed divider for DIV/MOD.
- It returns one result per entry over a valid/ready stream, then pulses `done`.

---
 rtl/instr_exec_unit.sv | 214 +++++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_unit.sv
// instr_exec_unit
//   Reads a range of entries from the 32-entry instruction register and
//   executes each one. Most opcodes use a single-cycle ALU. DIV and MOD use
//   an iterative signed divider that produces one quotient bit per cycle.
//   One result per entry is returned over a valid/ready stream, and done
//   pulses after the last result has been accepted.
//
// Ports
//   clk, reset_n         clock; asynchronous active-low reset
//   start                one-cycle command, accepted only when idle
//   start_ptr, count     first entry and number of entries (0..32)
//   busy                 high in every state except IDLE
//   read_pointer         entry address driven to the instruction register
//   iw_opc/op_a/op_b     combinational read data of the addressed entry
//   res_valid/res_ready  result handshake
//   res_data             64-bit signed result
//   res_opc, res_ptr     opcode and entry address of the result
//   res_dbz              divide-by-zero flag for the result
//   done                 one-cycle pulse after the final handshake
module instr_exec_unit (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [4:0]         start_ptr,
  input  logic [5:0]         count,
  output logic               busy,
  output logic [4:0]         read_pointer,
  input  logic [2:0]         iw_opc,
  input  logic signed [31:0] iw_op_a,
  input  logic signed [31:0] iw_op_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [63:0] res_data,
  output logic [2:0]         res_opc,
  output logic [4:0]         res_ptr,
  output logic               res_dbz,
  output logic               done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_DIVIDE = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_MOD   = 3'd7;

  logic [2:0]         state;
  logic [5:0]         remaining;
  logic [4:0]         div_cnt;

  logic [2:0]         opc_p0;
  logic signed [31:0] op_a_p0;
  logic signed [31:0] op_b_p0;

  // dvd_q starts as |dividend| and fills with quotient bits from the right
  // while the dividend bits are shifted out on the left.
  logic [31:0]        dvd_q;
  logic [31:0]        dvs;
  logic [31:0]        rem;
  logic               neg_q;
  logic               neg_r;

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] alu_res;
  logic               is_div;
  logic [32:0]        rem_sh;
  logic [32:0]        diff;
  logic [31:0]        rem_nxt;
  logic [31:0]        dvd_nxt;

  // Magnitude as unsigned; -2^31 maps to 2^31, which still fits in 32 bits.
  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    logic signed [31:0] n;
    n = -v;
    return v[31] ? n : v;
  endfunction

  // Applies the sign to a 32-bit unsigned magnitude, widening to 64 bits so
  // that +2^31 (from -2^31 / -1) is representable.
  function automatic logic signed [63:0] apply_sign(input logic [31:0] m,
                                                    input logic        neg);
    logic signed [63:0] e;
    e = $signed({32'd0, m});
    return neg ? -e : e;
  endfunction

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_FIN);
  assign is_div = (opc_p0[2:1] == 2'b11);
  assign a_ext  = {{32{op_a_p0[31]}}, op_a_p0};
  assign b_ext  = {{32{op_b_p0[31]}}, op_b_p0};

  always_comb begin
    alu_res = '0;
    case (opc_p0)
      OP_ZERO:  alu_res = '0;
      OP_PASSA: alu_res = a_ext;
      OP_PASSB: alu_res = b_ext;
      OP_ADD:   alu_res = a_ext + b_ext;
      OP_SUB:   alu_res = a_ext - b_ext;
      OP_MULT:  alu_res = a_ext * b_ext;
      default:  alu_res = '0;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract
  // the divisor if it fits, and record the quotient bit.
  always_comb begin
    rem_sh  = {rem, dvd_q[31]};
    diff    = rem_sh - {1'b0, dvs};
    rem_nxt = diff[32] ? rem_sh[31:0] : diff[31:0];
    dvd_nxt = {dvd_q[30:0], ~diff[32]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      div_cnt      <= '0;
      read_pointer <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_opc      <= '0;
      res_ptr      <= '0;
      res_dbz      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (count == 6'd0) begin
              state <= S_FIN;
            end else begin
              read_pointer <= start_ptr;
              remaining    <= count;
              state        <= S_FETCH;
            end
          end
        end
        // ---- FETCH -> EXEC: operands captured into _p0 ----
        S_FETCH: state <= S_EXEC;
        // ---- EXEC -> OUT / DIVIDE ----
        S_EXEC: begin
          if (is_div && (op_b_p0 != 32'sd0)) begin
            div_cnt <= '0;
            state   <= S_DIVIDE;
          end else begin
            res_valid <= 1'b1;
            res_data  <= alu_res;
            res_dbz   <= is_div;
            res_opc   <= opc_p0;
            res_ptr   <= read_pointer;
            state     <= S_OUT;
          end
        end
        // ---- DIVIDE -> OUT: last step folds into the sign fixup ----
        S_DIVIDE: begin
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) begin
            res_valid <= 1'b1;
            res_data  <= (opc_p0 == OP_MOD) ? apply_sign(rem_nxt, neg_r)
                                            : apply_sign(dvd_nxt, neg_q);
            res_dbz   <= 1'b0;
            res_opc   <= opc_p0;
            res_ptr   <= read_pointer;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            remaining <= remaining - 6'd1;
            if (remaining == 6'd1) begin
              state <= S_FIN;
            end else begin
              read_pointer <= read_pointer + 5'd1;
              state        <= S_FETCH;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (state == S_FETCH) begin
      opc_p0  <= iw_opc;
      op_a_p0 <= iw_op_a;
      op_b_p0 <= iw_op_b;
    end
    if (state == S_EXEC) begin
      dvd_q <= mag32(op_a_p0);
      dvs   <= mag32(op_b_p0);
      rem   <= '0;
      neg_q <= op_a_p0[31] ^ op_b_p0[31];
      neg_r <= op_a_p0[31];
    end else if (state == S_DIVIDE) begin
      dvd_q <= dvd_nxt;
      rem   <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
module tb_instr_exec_unit;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [4:0]         start_ptr;
  logic [5:0]         count;
  logic               busy;
  logic [4:0]         read_pointer;
  logic [2:0]         iw_opc;
  logic signed [31:0] iw_op_a;
  logic signed [31:0] iw_op_b;
  logic               res_valid;
  logic               res_ready;
  logic signed [63:0] res_data;
  logic [2:0]         res_opc;
  logic [4:0]         res_ptr;
  logic               res_dbz;
  logic               done;

  logic [2:0]         mem_opc [32];
  logic signed [31:0] mem_a   [32];
  logic signed [31:0] mem_b   [32];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign iw_opc  = mem_opc[read_pointer];
  assign iw_op_a = mem_a[read_pointer];
  assign iw_op_b = mem_b[read_pointer];

  instr_exec_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_ptr    (start_ptr),
    .count        (count),
    .busy         (busy),
    .read_pointer (read_pointer),
    .iw_opc       (iw_opc),
    .iw_op_a      (iw_op_a),
    .iw_op_b      (iw_op_b),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_opc      (res_opc),
    .res_ptr      (res_ptr),
    .res_dbz      (res_dbz),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      busy,         0);
    chk({tag, "_res_valid"}, res_valid,    0);
    chk({tag, "_done"},      done,         0);
    chk({tag, "_res_dbz"},   res_dbz,      0);
    chk({tag, "_res_data"},  res_data,     0);
    chk({tag, "_res_opc"},   res_opc,      0);
    chk({tag, "_res_ptr"},   res_ptr,      0);
    chk({tag, "_read_ptr"},  read_pointer, 0);
  endtask

  // Reference: plain 64-bit integer arithmetic. SystemVerilog division
  // truncates toward zero and % takes the dividend's sign.
  function automatic longint model_res(input logic [2:0] opc, input int a, input int b);
    longint la, lb;
    la = a;
    lb = b;
    case (opc)
      3'd0: return 0;
      3'd1: return la;
      3'd2: return lb;
      3'd3: return la + lb;
      3'd4: return la - lb;
      3'd5: return la * lb;
      3'd6: return (b == 0) ? 0 : la / lb;
      default: return (b == 0) ? 0 : la % lb;
    endcase
  endfunction

  function automatic int rnd_operand();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return -1;
      2: return int'(32'h8000_0000);
      3: return int'($urandom_range(0, 40)) - 20;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic fill_entry(input int p);
    mem_opc[p] = 3'($urandom_range(0, 7));
    mem_a[p]   = rnd_operand();
    mem_b[p]   = rnd_operand();
  endtask

  task automatic set_entry(input int p, input logic [2:0] o, input int a, input int b);
    mem_opc[p] = o;
    mem_a[p]   = a;
    mem_b[p]   = b;
  endtask

  // Issues a start, then consumes results with optional random back-pressure,
  // checking each result, first-result latency, stability while stalled, and
  // the done/busy timing. When inject is set, a second start is pulsed while
  // busy and must have no effect.
  task automatic run(input int sp, input int cnt, input bit rnd_ready, input bit inject);
    longint exp_d[$];
    int     exp_o[$];
    int     exp_p[$];
    bit     exp_z[$];
    int     first_lat;
    int     hs = 0;
    int     last_hs = 0;
    int     idx = 0;
    int     budget;
    bit     done_seen = 0;
    bit     first_seen = 0;
    bit     held = 0;
    logic [63:0] h_d;
    logic [2:0]  h_o;
    logic [4:0]  h_p;
    logic        h_z;
    budget = cnt * 90 + 20;
    for (int i = 0; i < cnt; i++) begin
      int p;
      p = (sp + i) % 32;
      exp_d.push_back(model_res(mem_opc[p], mem_a[p], mem_b[p]));
      exp_o.push_back(int'(mem_opc[p]));
      exp_p.push_back(p);
      exp_z.push_back(mem_opc[p] >= 3'd6 && mem_b[p] == 0);
    end
    first_lat = 3;
    if (cnt > 0 && mem_opc[sp] >= 3'd6 && mem_b[sp] != 0) first_lat = 35;

    @(negedge clk);
    start     = 1'b1;
    start_ptr = 5'(sp);
    count     = 6'(cnt);
    res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!done_seen && idx < budget) begin
      @(negedge clk);
      idx++;
      if (idx == 1) begin
        start = 1'b0;
        chk("busy_after_start", busy, 1);
      end
      if (inject && idx == 2) begin
        start     = 1'b1;
        start_ptr = 5'(sp + 5);
        count     = 6'd7;
      end
      if (inject && idx == 3) start = 1'b0;
      if (held) begin
        chk("stall_valid", res_valid, 1);
        chk("stall_data",  res_data,  h_d);
        chk("stall_opc",   res_opc,   h_o);
        chk("stall_ptr",   res_ptr,   h_p);
        chk("stall_dbz",   res_dbz,   h_z);
        held = 0;
      end
      if (res_valid && !first_seen) begin
        first_seen = 1;
        chk("first_latency", idx, first_lat);
      end
      if (done) begin
        done_seen = 1;
        chk("done_timing", idx, last_hs + 1);
        chk("done_after_all", hs, cnt);
      end
      res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_valid && res_ready) begin
        if (hs < cnt) begin
          chk("res_data", res_data, exp_d[hs]);
          chk("res_opc",  res_opc,  exp_o[hs]);
          chk("res_ptr",  res_ptr,  exp_p[hs]);
          chk("res_dbz",  res_dbz,  exp_z[hs]);
        end else begin
          chk("extra_result", hs, cnt);
        end
        hs++;
        last_hs = idx;
      end else if (res_valid) begin
        held = 1;
        h_d  = res_data;
        h_o  = res_opc;
        h_p  = res_ptr;
        h_z  = res_dbz;
      end
    end
    chk("done_seen", done_seen, 1);
    chk("result_count", hs, cnt);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset_n   = 1'b0;
    start     = 1'b0;
    start_ptr = '0;
    count     = '0;
    res_ready = 1'b1;
    for (int i = 0; i < 32; i++) fill_entry(i);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // Basic ALU sequence.
    set_entry(0, 3'd3, 5, 7);
    set_entry(1, 3'd4, 3, 10);
    set_entry(2, 3'd5, -4, 6);
    run(0, 3, 0, 0);

    // Signed divide and modulo.
    set_entry(4, 3'd6, -17, 5);
    set_entry(5, 3'd7, -17, 5);
    run(4, 2, 0, 0);

    // Divide by zero and the overflow corner.
    set_entry(6, 3'd6, 9, 0);
    run(6, 1, 0, 0);
    set_entry(6, 3'd7, 9, 0);
    run(6, 1, 0, 0);
    set_entry(8, 3'd6, int'(32'h8000_0000), -1);
    set_entry(9, 3'd7, int'(32'h8000_0000), -1);
    run(8, 2, 0, 0);

    // Pointer wrap with random back-pressure.
    for (int p = 0; p < 4; p++) fill_entry((30 + p) % 32);
    run(30, 4, 1, 0);

    // Empty command, then a start while busy.
    run(17, 0, 0, 0);
    for (int p = 12; p < 15; p++) fill_entry(p);
    run(12, 3, 0, 1);

    // Reset while dividing.
    set_entry(10, 3'd6, 1000, 3);
    @(negedge clk);
    start = 1'b1; start_ptr = 5'd10; count = 6'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_in_divide", busy, 1);
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("rst_divide");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst_divide", busy, 0);
    run(10, 1, 0, 0);

    // Reset while a result is stalled in OUT.
    set_entry(11, 3'd3, 100, -1);
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b1; start_ptr = 5'd11; count = 6'd1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    repeat (3) @(negedge clk);
    chk("stalled_valid", res_valid, 1);
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("rst_out");
    @(negedge clk);
    reset_n = 1'b1;
    run(10, 2, 1, 0);

    // Randomised sequences.
    for (int r = 0; r < 6; r++) begin
      int sp, cnt;
      sp  = $urandom_range(0, 31);
      cnt = $urandom_range(1, 8);
      for (int i = 0; i < cnt; i++) fill_entry((sp + i) % 32);
      run(sp, cnt, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
